// File: rtl/scanline_fx_if.sv
// Video pixel/sync bundle for the scanline darkening stage: raw inputs and the
// registered, time-aligned outputs.
interface scanline_fx_if #(
    parameter int unsigned CW = 6
);
    logic [3*CW-1:0] din;
    logic            hs_in;
    logic            vs_in;
    logic            de_in;
    logic [3*CW-1:0] dout;
    logic            hs_out;
    logic            vs_out;
    logic            de_out;

    modport master (
        output din, hs_in, vs_in, de_in,
        input  dout, hs_out, vs_out, de_out
    );

    modport slave (
        input  din, hs_in, vs_in, de_in,
        output dout, hs_out, vs_out, de_out
    );
endinterface

// File: rtl/scanline_fx.sv
// CRT scanline emulation: dims selected output lines by 25/50/75 %, with the
// mode, line period and phase latched once per frame on the vsync falling edge.
module scanline_fx #(
    parameter int unsigned CW = 6,
    parameter int unsigned PW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    scanlines,
    input  logic [PW-1:0] period,
    input  logic          phase,
    scanline_fx_if.slave  vid
);

    typedef enum logic [1:0] {
        DIM_OFF = 2'd0,
        DIM_25  = 2'd1,
        DIM_50  = 2'd2,
        DIM_75  = 2'd3
    } dim_mode_e;

    dim_mode_e       mode_q, mode_d;
    logic [PW-1:0]   period_q, period_d;
    logic            phase_q, phase_d;
    logic [PW-1:0]   line_cnt_q, line_cnt_d;
    logic            old_hs_q, old_vs_q;
    logic [3*CW-1:0] dout_q, dout_d;
    logic            hs_out_q, vs_out_q, de_out_q;

    logic            hs_fall;
    logic            vs_fall;
    logic            dim;
    dim_mode_e       eff_mode;

    function automatic logic [CW-1:0] dim_chan(input logic [CW-1:0] c, input dim_mode_e m);
        logic [CW-1:0] r;
        case (m)
            DIM_25:  r = (c >> 1) + (c >> 2);
            DIM_50:  r = c >> 1;
            DIM_75:  r = c >> 2;
            default: r = c;
        endcase
        return r;
    endfunction

    always_comb begin
        hs_fall    = old_hs_q & ~vid.hs_in;
        vs_fall    = old_vs_q & ~vid.vs_in;

        mode_d     = mode_q;
        period_d   = period_q;
        phase_d    = phase_q;
        line_cnt_d = line_cnt_q;

        if (vs_fall) begin
            mode_d     = dim_mode_e'(scanlines);
            period_d   = period;
            phase_d    = phase;
            line_cnt_d = '0;
        end else if (hs_fall) begin
            // Compare against the latched period so a shrunk period still wraps.
            line_cnt_d = (line_cnt_q >= period_q) ? '0 : line_cnt_q + PW'(1);
        end

        // Current pixel uses the pre-update count and pre-latch settings.
        dim      = (period_q != '0) && (line_cnt_q == (phase_q ? PW'(0) : period_q));
        eff_mode = dim ? mode_q : DIM_OFF;

        dout_d = '0;
        if (vid.de_in) begin
            for (int unsigned i = 0; i < 3; i++) begin
                dout_d[i*CW +: CW] = dim_chan(vid.din[i*CW +: CW], eff_mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= DIM_OFF;
            period_q   <= '0;
            phase_q    <= 1'b0;
            line_cnt_q <= '0;
            old_hs_q   <= 1'b0;
            old_vs_q   <= 1'b0;
            dout_q     <= '0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
            line_cnt_q <= line_cnt_d;
            old_hs_q   <= vid.hs_in;
            old_vs_q   <= vid.vs_in;
            dout_q     <= dout_d;
            hs_out_q   <= vid.hs_in;
            vs_out_q   <= vid.vs_in;
            de_out_q   <= vid.de_in;
        end
    end

    assign vid.dout   = dout_q;
    assign vid.hs_out = hs_out_q;
    assign vid.vs_out = vs_out_q;
    assign vid.de_out = de_out_q;

endmodule

// File: tb/tb_scanline_fx.sv
// Directed bench for scanline_fx: a CW=6 instance for the main features and a
// CW=8 instance for the wider-channel dimming arithmetic.
module tb_scanline_fx;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] scanlines, scanlines8;
    logic [1:0] period, period8;
    logic       phase, phase8;

    int unsigned asserts = 0;
    int unsigned fails   = 0;

    localparam logic [17:0] W63 = {6'd63, 6'd63, 6'd63};
    localparam logic [17:0] W31 = {6'd31, 6'd31, 6'd31};
    localparam logic [17:0] W15 = {6'd15, 6'd15, 6'd15};
    localparam logic [17:0] P1  = {6'd63, 6'd32, 6'd5};
    localparam logic [17:0] D1  = {6'd46, 6'd24, 6'd3};
    localparam logic [23:0] Q8  = {8'd255, 8'd128, 8'd1};
    localparam logic [23:0] Q8D = {8'd190, 8'd96, 8'd0};

    scanline_fx_if #(.CW(6)) vif ();
    scanline_fx_if #(.CW(8)) vif8 ();

    scanline_fx #(.CW(6), .PW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scanlines (scanlines),
        .period    (period),
        .phase     (phase),
        .vid       (vif)
    );

    scanline_fx #(.CW(8), .PW(2)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .scanlines (scanlines8),
        .period    (period8),
        .phase     (phase8),
        .vid       (vif8)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [17:0] d, input logic de, input logic hs, input logic vs);
        vif.din   = d;
        vif.de_in = de;
        vif.hs_in = hs;
        vif.vs_in = vs;
        tick();
    endtask

    task automatic drive8(input logic [23:0] d, input logic de, input logic hs, input logic vs);
        vif8.din   = d;
        vif8.de_in = de;
        vif8.hs_in = hs;
        vif8.vs_in = vs;
        tick();
    endtask

    task automatic vsync;
        drive('0, 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hsync;
        drive('0, 1'b0, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(W63, 1'b1, 1'b1, 1'b1);
        asserts++;
        if (vif.dout !== 18'd0) begin
            fails++; $display("FAIL rst_dout got %h want %h", vif.dout, 18'd0);
        end
        asserts++;
        if ({vif.hs_out, vif.vs_out, vif.de_out} !== 3'b000) begin
            fails++; $display("FAIL rst_flags got %b want 000", {vif.hs_out, vif.vs_out, vif.de_out});
        end
        reset = 1'b0;
        scanlines = 2'd3; period = 2'd1; phase = 1'b0;
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63 || {vif.hs_out, vif.vs_out, vif.de_out} !== 3'b001) begin
            fails++; $display("FAIL rst_pass got %h/%b want %h/001", vif.dout, {vif.hs_out, vif.vs_out, vif.de_out}, W63);
        end
        drive(W63, 1'b1, 1'b1, 1'b0);
        asserts++;
        if (vif.dout !== W63 || {vif.hs_out, vif.vs_out, vif.de_out} !== 3'b101) begin
            fails++; $display("FAIL rst_hs got %h/%b want %h/101", vif.dout, {vif.hs_out, vif.vs_out, vif.de_out}, W63);
        end
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63) begin
            fails++; $display("FAIL rst_nodim got %h want %h", vif.dout, W63);
        end
        drive(W63, 1'b0, 1'b0, 1'b1);
        asserts++;
        if (vif.dout !== 18'd0 || {vif.hs_out, vif.vs_out, vif.de_out} !== 3'b010) begin
            fails++; $display("FAIL rst_vs got %h/%b want 0/010", vif.dout, {vif.hs_out, vif.vs_out, vif.de_out});
        end
    endtask

    task automatic test_mode1;
        scanlines = 2'd1; period = 2'd1; phase = 1'b0;
        vsync();
        drive(P1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== P1) begin fails++; $display("FAIL m1_line0 got %h want %h", vif.dout, P1); end
        hsync();
        drive(P1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== D1) begin fails++; $display("FAIL m1_line1 got %h want %h", vif.dout, D1); end
        hsync();
        drive(P1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== P1) begin fails++; $display("FAIL m1_line2 got %h want %h", vif.dout, P1); end
        drive(P1, 1'b1, 1'b1, 1'b0);
        drive(P1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== P1) begin fails++; $display("FAIL m1_fallcycle got %h want %h", vif.dout, P1); end
        drive(P1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== D1) begin fails++; $display("FAIL m1_line3 got %h want %h", vif.dout, D1); end
    endtask

    task automatic test_modes23;
        scanlines = 2'd2; period = 2'd1; phase = 1'b0;
        vsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63) begin fails++; $display("FAIL m2_line0 got %h want %h", vif.dout, W63); end
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W31) begin fails++; $display("FAIL m2_line1 got %h want %h", vif.dout, W31); end
        scanlines = 2'd3;
        vsync();
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W15) begin fails++; $display("FAIL m3_line1 got %h want %h", vif.dout, W15); end
        period = 2'd0;
        vsync();
        for (int i = 0; i < 3; i++) begin
            drive(W63, 1'b1, 1'b0, 1'b0);
            asserts++;
            if (vif.dout !== W63) begin fails++; $display("FAIL p0_line%0d got %h want %h", i, vif.dout, W63); end
            hsync();
        end
    endtask

    task automatic test_period_phase;
        logic [17:0] exp;
        scanlines = 2'd2; period = 2'd2; phase = 1'b1;
        vsync();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) period = 2'd1;
            exp = (i % 3 == 0) ? W31 : W63;
            drive(W63, 1'b1, 1'b0, 1'b0);
            asserts++;
            if (vif.dout !== exp) begin fails++; $display("FAIL p2ph1_line%0d got %h want %h", i, vif.dout, exp); end
            hsync();
        end
        vsync();
        for (int i = 0; i < 3; i++) begin
            exp = (i % 2 == 0) ? W31 : W63;
            drive(W63, 1'b1, 1'b0, 1'b0);
            asserts++;
            if (vif.dout !== exp) begin fails++; $display("FAIL p1ph1_line%0d got %h want %h", i, vif.dout, exp); end
            hsync();
        end
    endtask

    task automatic test_blank;
        scanlines = 2'd3; period = 2'd1; phase = 1'b0;
        vsync();
        drive(W63, 1'b0, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== 18'd0 || vif.de_out !== 1'b0) begin
            fails++; $display("FAIL blank_line0 got %h/%b want 0/0", vif.dout, vif.de_out);
        end
        hsync();
        drive(W63, 1'b0, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== 18'd0) begin fails++; $display("FAIL blank_line1 got %h want 0", vif.dout); end
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W15) begin fails++; $display("FAIL blank_after got %h want %h", vif.dout, W15); end
    endtask

    task automatic test_simultaneous;
        scanlines = 2'd2; period = 2'd2; phase = 1'b1;
        vsync();
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63) begin fails++; $display("FAIL sim_line1 got %h want %h", vif.dout, W63); end
        drive('0, 1'b0, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b0);
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W31) begin fails++; $display("FAIL sim_both_fall got %h want %h", vif.dout, W31); end
        hsync();
        drive('0, 1'b0, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0, 1'b0);
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63) begin fails++; $display("FAIL held_hs got %h want %h", vif.dout, W63); end
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W31) begin fails++; $display("FAIL held_hs_next got %h want %h", vif.dout, W31); end
    endtask

    task automatic test_reset_mid;
        scanlines = 2'd2; period = 2'd1; phase = 1'b0;
        vsync();
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W31) begin fails++; $display("FAIL rmid_pre got %h want %h", vif.dout, W31); end
        reset = 1'b1;
        drive(W63, 1'b1, 1'b1, 1'b0);
        asserts++;
        if (vif.dout !== 18'd0 || {vif.hs_out, vif.vs_out, vif.de_out} !== 3'b000) begin
            fails++; $display("FAIL rmid_reset got %h/%b want 0/000", vif.dout, {vif.hs_out, vif.vs_out, vif.de_out});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(W63, 1'b1, 1'b0, 1'b0);
            asserts++;
            if (vif.dout !== W63) begin fails++; $display("FAIL rmid_pass%0d got %h want %h", i, vif.dout, W63); end
            hsync();
        end
        vsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W63) begin fails++; $display("FAIL rmid_line0 got %h want %h", vif.dout, W63); end
        hsync();
        drive(W63, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif.dout !== W31) begin fails++; $display("FAIL rmid_line1 got %h want %h", vif.dout, W31); end
    endtask

    task automatic test_cw8;
        scanlines8 = 2'd1; period8 = 2'd1; phase8 = 1'b0;
        drive8('0, 1'b0, 1'b0, 1'b1);
        drive8('0, 1'b0, 1'b0, 1'b0);
        drive8(Q8, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif8.dout !== Q8) begin fails++; $display("FAIL cw8_line0 got %h want %h", vif8.dout, Q8); end
        drive8('0, 1'b0, 1'b1, 1'b0);
        drive8('0, 1'b0, 1'b0, 1'b0);
        drive8(Q8, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (vif8.dout !== Q8D) begin fails++; $display("FAIL cw8_line1 got %h want %h", vif8.dout, Q8D); end
        drive8(Q8, 1'b0, 1'b0, 1'b0);
        asserts++;
        if (vif8.dout !== 24'd0) begin fails++; $display("FAIL cw8_blank got %h want 0", vif8.dout); end
    endtask

    initial begin
        reset = 1'b1;
        scanlines = '0; period = '0; phase = 1'b0;
        scanlines8 = '0; period8 = '0; phase8 = 1'b0;
        vif.din = '0; vif.de_in = 1'b0; vif.hs_in = 1'b0; vif.vs_in = 1'b0;
        vif8.din = '0; vif8.de_in = 1'b0; vif8.hs_in = 1'b0; vif8.vs_in = 1'b0;
        test_reset();
        test_mode1();
        test_modes23();
        test_period_phase();
        test_blank();
        test_simultaneous();
        test_reset_mid();
        test_cw8();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
